bk_sd_sequencer: RTL and testbench

BK_SD_SEQUENCER -- requirements
Module: bk_sd_sequencer

---
 rtl/tgfx_bk_pkg.sv | 24 ++
 rtl/bk_sd_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_bk_sd_sequencer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tgfx_bk_pkg.sv
// Shared types and constants for the backup-RAM SD sequencer.
package tgfx_bk_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_FORMAT,
    S_DONE
  } state_t;

  // Default number of 512-byte sectors in one save slot.
  localparam int DEF_SECTORS = 16;

  // Save-image header words, entry 0 is written first (address 0).
  localparam logic [3:0][15:0] HDR = {16'h8010, 16'h8800, 16'h4D42, 16'h5548};

  // Header word for a given header address.
  function automatic logic [15:0] hdr_word(input logic [1:0] addr);
    return HDR[addr];
  endfunction

endpackage

// File: rtl/bk_sd_sequencer.sv
// Backup-RAM load/save/format sequencer driving the hps_io block-device
// handshake: one sd_rd/sd_wr request per sector of the selected slot,
// a per-request ack timeout, and a 4-word header write for format.
module bk_sd_sequencer
  import tgfx_bk_pkg::*;
#(
  parameter int SECTORS = DEF_SECTORS,
  parameter int SLOT_W  = 2,
  parameter int TIMEOUT = 1 << 24
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              bk_ena,
  input  logic              load_req,
  input  logic              save_req,
  input  logic              format_req,
  input  logic [SLOT_W-1:0] slot,
  output logic [31:0]       sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  input  logic              sd_ack,
  output logic [1:0]        fmt_addr,
  output logic [15:0]       fmt_data,
  output logic              fmt_we,
  output logic              busy,
  output logic              loading,
  output logic              done,
  output logic              err
);

  localparam int IDX_W = (SECTORS > 1) ? $clog2(SECTORS) : 1;
  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SECTORS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  state_t state_reg, state_next;

  logic load_q_reg, save_q_reg, format_q_reg, ack_q_reg;
  logic load_rise, save_rise, format_rise, ack_rise, ack_fall;

  logic [SLOT_W-1:0] slot_reg, slot_next;
  logic              dir_reg, dir_next;   // 1 = load (sd_rd), 0 = save (sd_wr)
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [TMO_W-1:0]  tmo_reg, tmo_next;
  logic [31:0]       lba_reg, lba_next;
  logic              rd_reg, rd_next;
  logic              wr_reg, wr_next;
  logic [1:0]        fmt_addr_reg, fmt_addr_next;
  logic [15:0]       fmt_data_reg, fmt_data_next;
  logic              fmt_we_reg, fmt_we_next;
  logic              busy_reg, busy_next;
  logic              loading_reg, loading_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;

  // Sector address of a slot/index pair; SECTORS is a power of two.
  function automatic logic [31:0] lba_of(input logic [SLOT_W-1:0] s,
                                         input logic [IDX_W-1:0] i);
    return 32'(s) * 32'(SECTORS) + 32'(i);
  endfunction

  assign load_rise   = load_req   & ~load_q_reg;
  assign save_rise   = save_req   & ~save_q_reg;
  assign format_rise = format_req & ~format_q_reg;
  assign ack_rise    = sd_ack     & ~ack_q_reg;
  assign ack_fall    = ~sd_ack    &  ack_q_reg;

  // Edge-detect copies follow the inputs even in reset, so levels held
  // high through reset never look like a fresh edge afterwards.
  always_ff @(posedge clk_sys) begin
    load_q_reg   <= load_req;
    save_q_reg   <= save_req;
    format_q_reg <= format_req;
    ack_q_reg    <= sd_ack;
  end

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_next    = state_reg;
    slot_next     = slot_reg;
    dir_next      = dir_reg;
    idx_next      = idx_reg;
    tmo_next      = tmo_reg;
    lba_next      = lba_reg;
    rd_next       = rd_reg;
    wr_next       = wr_reg;
    fmt_addr_next = fmt_addr_reg;
    fmt_data_next = fmt_data_reg;
    fmt_we_next   = fmt_we_reg;
    busy_next     = busy_reg;
    loading_next  = loading_reg;
    done_next     = 1'b0;
    err_next      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (bk_ena && (load_rise || save_rise)) begin
          // Load wins over a simultaneous save.
          state_next   = S_REQ;
          slot_next    = slot;
          dir_next     = load_rise;
          idx_next     = '0;
          tmo_next     = '0;
          lba_next     = lba_of(slot, '0);
          rd_next      = load_rise;
          wr_next      = ~load_rise;
          busy_next    = 1'b1;
          loading_next = load_rise;
        end else if (format_rise) begin
          state_next    = S_FORMAT;
          fmt_addr_next = 2'd0;
          fmt_data_next = hdr_word(2'd0);
          fmt_we_next   = 1'b1;
          busy_next     = 1'b1;
          loading_next  = 1'b0;
        end
      end

      S_REQ: begin
        if (ack_rise) begin
          rd_next    = 1'b0;
          wr_next    = 1'b0;
          state_next = S_XFER;
        end else if (tmo_reg == TMO_LAST) begin
          rd_next      = 1'b0;
          wr_next      = 1'b0;
          err_next     = 1'b1;
          busy_next    = 1'b0;
          loading_next = 1'b0;
          state_next   = S_IDLE;
        end else begin
          tmo_next = tmo_reg + TMO_ONE;
        end
      end

      S_XFER: begin
        if (ack_fall) begin
          if (idx_reg == LAST_IDX) begin
            state_next = S_DONE;
            done_next  = 1'b1;
          end else begin
            idx_next   = idx_reg + IDX_ONE;
            lba_next   = lba_of(slot_reg, idx_reg + IDX_ONE);
            rd_next    = dir_reg;
            wr_next    = ~dir_reg;
            tmo_next   = '0;
            state_next = S_REQ;
          end
        end
      end

      S_FORMAT: begin
        if (fmt_addr_reg == 2'd3) begin
          fmt_we_next = 1'b0;
          state_next  = S_DONE;
          done_next   = 1'b1;
        end else begin
          fmt_addr_next = fmt_addr_reg + 2'd1;
          fmt_data_next = hdr_word(fmt_addr_reg + 2'd1);
        end
      end

      S_DONE: begin
        busy_next    = 1'b0;
        loading_next = 1'b0;
        state_next   = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any request in the same edge.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      slot_reg     <= '0;
      dir_reg      <= 1'b0;
      idx_reg      <= '0;
      tmo_reg      <= '0;
      lba_reg      <= '0;
      rd_reg       <= 1'b0;
      wr_reg       <= 1'b0;
      fmt_addr_reg <= '0;
      fmt_data_reg <= '0;
      fmt_we_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      loading_reg  <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      slot_reg     <= slot_next;
      dir_reg      <= dir_next;
      idx_reg      <= idx_next;
      tmo_reg      <= tmo_next;
      lba_reg      <= lba_next;
      rd_reg       <= rd_next;
      wr_reg       <= wr_next;
      fmt_addr_reg <= fmt_addr_next;
      fmt_data_reg <= fmt_data_next;
      fmt_we_reg   <= fmt_we_next;
      busy_reg     <= busy_next;
      loading_reg  <= loading_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

  assign sd_lba   = lba_reg;
  assign sd_rd    = rd_reg;
  assign sd_wr    = wr_reg;
  assign fmt_addr = fmt_addr_reg;
  assign fmt_data = fmt_data_reg;
  assign fmt_we   = fmt_we_reg;
  assign busy     = busy_reg;
  assign loading  = loading_reg;
  assign done     = done_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_bk_sd_sequencer.sv
// Self-checking bench for bk_sd_sequencer: table of whole operations,
// hand-written corner sequences, and random operations against a
// behavioural model of which sector requests each operation must produce.
module tb_bk_sd_sequencer;

  localparam int SECTORS = 16;
  localparam int SLOT_W  = 2;
  localparam int TIMEOUT = 64;

  localparam int OP_LOAD = 0;
  localparam int OP_SAVE = 1;
  localparam int OP_FMT  = 2;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic              reset_n, bk_ena, load_req, save_req, format_req, sd_ack;
  logic [SLOT_W-1:0] slot;
  logic [31:0]       sd_lba;
  logic              sd_rd, sd_wr, fmt_we, busy, loading, done, err;
  logic [1:0]        fmt_addr;
  logic [15:0]       fmt_data;

  bk_sd_sequencer #(.SECTORS(SECTORS), .SLOT_W(SLOT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .bk_ena(bk_ena),
    .load_req(load_req), .save_req(save_req), .format_req(format_req),
    .slot(slot), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .fmt_addr(fmt_addr), .fmt_data(fmt_data), .fmt_we(fmt_we),
    .busy(busy), .loading(loading), .done(done), .err(err)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] hdr_exp [4] = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- ack responder ----------------
  bit ack_en   = 1'b1;
  int rise_dly = 5;
  int fall_dly = 20;

  initial begin
    sd_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (ack_en && (sd_rd || sd_wr) && !sd_ack) begin
        repeat (rise_dly - 1) @(negedge clk_sys);
        sd_ack = 1'b1;
        repeat (fall_dly) @(negedge clk_sys);
        sd_ack = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  typedef struct {
    logic [31:0] lba;
    logic        rd;
  } req_t;

  req_t        req_q[$];
  logic [17:0] fmt_q[$];
  int          n_done, n_err, n_viol, act_cycles;
  logic        prev_act = 1'b0;

  initial begin
    logic act;
    forever begin
      @(negedge clk_sys);
      act = sd_rd | sd_wr;
      if (act === 1'b1 && prev_act !== 1'b1) req_q.push_back(req_t'{sd_lba, sd_rd});
      prev_act = act;
      if (act === 1'b1) act_cycles++;
      if (fmt_we === 1'b1) fmt_q.push_back({fmt_addr, fmt_data});
      if (done === 1'b1) n_done++;
      if (err === 1'b1) n_err++;
      if (sd_rd === 1'b1 && sd_wr === 1'b1) n_viol++;
      if (act === 1'b1 && (loading !== sd_rd || busy !== 1'b1)) n_viol++;
      if (fmt_we === 1'b1 && (busy !== 1'b1 || act === 1'b1)) n_viol++;
      if (done === 1'b1 && busy !== 1'b1) n_viol++;
    end
  end

  task automatic mon_clear();
    req_q.delete();
    fmt_q.delete();
    n_done = 0; n_err = 0; n_viol = 0; act_cycles = 0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic pulse(input int op);
    @(negedge clk_sys);
    case (op)
      OP_LOAD: load_req   = 1'b1;
      OP_SAVE: save_req   = 1'b1;
      default: format_req = 1'b1;
    endcase
    repeat (2) @(negedge clk_sys);
    load_req = 1'b0; save_req = 1'b0; format_req = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int c = 0;
    repeat (4) @(negedge clk_sys);
    while (busy !== 1'b0 && c < max_cycles) begin
      @(negedge clk_sys);
      c++;
    end
    if (busy !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL %s wait: busy=%0b after %0d cycles, required 0", name, busy, c);
    end
    repeat (3) @(negedge clk_sys);
  endtask

  // Compare what the monitor saw against what an operation must produce.
  task automatic compare(input string name, input int n_req, input int first_lba,
                         input bit rd, input int n_fmt, input int exp_done, input int exp_err);
    check($sformatf("%s req count", name), req_q.size(), n_req);
    for (int i = 0; i < req_q.size() && i < n_req; i++) begin
      check($sformatf("%s lba[%0d]", name, i), req_q[i].lba, first_lba + i);
      check($sformatf("%s dir[%0d]", name, i), req_q[i].rd, rd);
    end
    check($sformatf("%s fmt count", name), fmt_q.size(), n_fmt);
    for (int i = 0; i < fmt_q.size() && i < n_fmt; i++)
      check($sformatf("%s fmt[%0d]", name, i), fmt_q[i], {i[1:0], hdr_exp[i]});
    check($sformatf("%s done pulses", name), n_done, exp_done);
    check($sformatf("%s err pulses", name), n_err, exp_err);
    check($sformatf("%s protocol violations", name), n_viol, 0);
    $display("txn %s: reqs=%0d fmt=%0d done=%0d err=%0d", name, req_q.size(), fmt_q.size(), n_done, n_err);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int op;
    int sl;
    bit ena;
    int n_req;
    int first_lba;
    bit rd;
    int n_fmt;
    int n_done;
  } vec_t;

  vec_t vecs[6];

  // Global watchdog.
  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; bk_ena = 1'b0; load_req = 1'b1; save_req = 1'b0;
    format_req = 1'b0; slot = '0;

    vecs[0] = '{OP_LOAD, 2, 1'b1, 16, 32, 1'b1, 0, 1};
    vecs[1] = '{OP_SAVE, 0, 1'b1, 16,  0, 1'b0, 0, 1};
    vecs[2] = '{OP_FMT,  1, 1'b0,  0,  0, 1'b0, 4, 1};
    vecs[3] = '{OP_LOAD, 1, 1'b0,  0,  0, 1'b0, 0, 0};
    vecs[4] = '{OP_SAVE, 3, 1'b1, 16, 48, 1'b0, 0, 1};
    vecs[5] = '{OP_SAVE, 3, 1'b0,  0,  0, 1'b0, 0, 0};

    // Reset state with load_req held high through reset.
    repeat (3) @(negedge clk_sys);
    check("reset flags", {sd_rd, sd_wr, fmt_we, busy, loading, done, err}, 0);
    check("reset lba", sd_lba, 0);
    check("reset fmt", {fmt_addr, fmt_data}, 0);
    mon_clear();
    reset_n = 1'b1;
    repeat (10) @(negedge clk_sys);
    check("held load after reset busy", busy, 0);
    check("held load after reset reqs", req_q.size(), 0);
    load_req = 1'b0;
    repeat (2) @(negedge clk_sys);
    $display("txn reset: busy=%0b reqs=%0d", busy, req_q.size());

    // Table-driven whole operations.
    for (int v = 0; v < 6; v++) begin
      mon_clear();
      bk_ena = vecs[v].ena;
      slot   = SLOT_W'(vecs[v].sl);
      ack_en = 1'b1;
      pulse(vecs[v].op);
      wait_idle($sformatf("vec%0d", v), 1000);
      compare($sformatf("vec%0d", v), vecs[v].n_req, vecs[v].first_lba, vecs[v].rd,
              vecs[v].n_fmt, vecs[v].n_done, 0);
    end

    // Load with no ack: request held for exactly TIMEOUT cycles, one err.
    mon_clear();
    bk_ena = 1'b1; slot = 2'd0; ack_en = 1'b0;
    pulse(OP_LOAD);
    wait_idle("timeout", 200);
    check("timeout request width", act_cycles, TIMEOUT);
    compare("timeout", 1, 0, 1'b1, 0, 0, 1);
    // A new save must then be accepted.
    mon_clear();
    ack_en = 1'b1; slot = 2'd2;
    pulse(OP_SAVE);
    wait_idle("save after timeout", 1000);
    compare("save after timeout", 16, 32, 1'b0, 0, 1, 0);

    // Load and save rise together, a save edge mid-load, bk_ena drops late.
    mon_clear();
    bk_ena = 1'b1; slot = 2'd1;
    @(negedge clk_sys);
    load_req = 1'b1; save_req = 1'b1;
    repeat (20) @(negedge clk_sys);
    save_req = 1'b0;
    repeat (40) @(negedge clk_sys);
    save_req = 1'b1;
    repeat (5) @(negedge clk_sys);
    save_req = 1'b0; load_req = 1'b0;
    repeat (40) @(negedge clk_sys);
    bk_ena = 1'b0;
    wait_idle("simultaneous", 1000);
    repeat (40) @(negedge clk_sys);
    compare("simultaneous", 16, 16, 1'b1, 0, 1, 0);
    bk_ena = 1'b1;

    // Reset during sector 7 of a load, load_req held high throughout.
    begin
      int c = 0;
      mon_clear();
      slot = 2'd1;
      @(negedge clk_sys);
      load_req = 1'b1;
      while (!(req_q.size() == 8 && sd_rd === 1'b1) && c < 1000) begin
        @(negedge clk_sys);
        c++;
      end
      check("reach sector 7", (req_q.size() == 8 && sd_rd === 1'b1), 1);
      check("sector 7 lba", sd_lba, 16 + 7);
      reset_n = 1'b0;
      @(negedge clk_sys);
      check("mid reset rd", sd_rd, 0);
      check("mid reset busy", busy, 0);
      check("mid reset loading", loading, 0);
      repeat (2) @(negedge clk_sys);
      reset_n = 1'b1;
      repeat (60) @(negedge clk_sys);
      check("after reset no new request", req_q.size(), 8);
      check("after reset busy", busy, 0);
      check("after reset done", n_done, 0);
      load_req = 1'b0;
      repeat (5) @(negedge clk_sys);
      $display("txn midreset: reqs=%0d busy=%0b", req_q.size(), busy);
    end

    // Random operations against the behavioural model.
    for (int r = 0; r < 8; r++) begin
      int op, sl, e_req, e_fmt, e_done;
      bit ena;
      op       = int'($urandom_range(0, 2));
      sl       = int'($urandom_range(0, 3));
      ena      = ($urandom_range(0, 3) != 0);
      rise_dly = int'($urandom_range(1, 6));
      fall_dly = int'($urandom_range(1, 10));
      // Model: load/save need bk_ena and cover every sector of the slot;
      // format ignores bk_ena and writes the four header words.
      e_req  = (op != OP_FMT && ena) ? SECTORS : 0;
      e_fmt  = (op == OP_FMT) ? 4 : 0;
      e_done = (e_req != 0 || e_fmt != 0) ? 1 : 0;
      mon_clear();
      bk_ena = ena;
      slot   = SLOT_W'(sl);
      pulse(op);
      wait_idle($sformatf("rand%0d", r), 1000);
      compare($sformatf("rand%0d op=%0d slot=%0d ena=%0b", r, op, sl, ena),
              e_req, sl * SECTORS, (op == OP_LOAD), e_fmt, e_done, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
